// File: rtl/spi_pkg.sv
// Shared constants for the SPI shift engine: state/bit-order encodings, default width, counter sizing.
package spi_pkg;

  localparam int SPI_DATA_LEN = 8;

  typedef enum logic {
    SPI_IDLE  = 1'b0,
    SPI_SHIFT = 1'b1
  } spi_state_e;

  localparam logic SPI_LSB_FIRST = 1'b0;
  localparam logic SPI_MSB_FIRST = 1'b1;

  // Wide enough to hold the value DATA_LEN itself, not just DATA_LEN-1.
  function automatic int spi_cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Frame bit counter: clear, count on enable, flag the strobe that completes the frame.
module spi_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == len_i - CNT_W'(1));

endmodule

// File: rtl/spi_shift_engine.sv
// SPI serialiser/deserialiser with configurable frame length and bit order.
// Optional internal loopback (serial_out fed back as receive bit) under SPI_SHIFT_LOOPBACK_EN.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_LEN = SPI_DATA_LEN,
  parameter int CNT_W    = spi_cnt_w(DATA_LEN)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [DATA_LEN-1:0] tx_data_i,
  input  logic [CNT_W-1:0]    frame_len_i,
  input  logic                msb_first_i,
  input  logic                shift_en_i,
  input  logic                abort_i,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic                loopback_i,
`endif
  input  logic                serial_in_i,
  output logic                serial_out_o,
  output logic [DATA_LEN-1:0] rx_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    bit_cnt_o
);

  spi_state_e          state_q, state_d;
  logic [DATA_LEN-1:0] sreg_q, sreg_d;
  logic [DATA_LEN-1:0] rx_q, rx_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic                msb_q, msb_d;

  logic [CNT_W-1:0]    eff_len, top_idx;
  logic [DATA_LEN-1:0] len_mask, shifted;
  logic                msb_bit, rx_bit;
  logic                cnt_clr, cnt_en, cnt_last;

  // 0 and oversize lengths both mean a full-width frame.
  assign eff_len = (frame_len_i == '0 || frame_len_i > CNT_W'(DATA_LEN))
                   ? CNT_W'(DATA_LEN) : frame_len_i;
  assign top_idx  = len_q - CNT_W'(1);
  assign len_mask = ~({DATA_LEN{1'b1}} << len_q);

  always_comb begin
    msb_bit = 1'b0;
    for (int i = 0; i < DATA_LEN; i++) begin
      if (CNT_W'(i) == top_idx) msb_bit = sreg_q[i];
    end
  end

  assign serial_out_o = (msb_q == SPI_MSB_FIRST) ? msb_bit : sreg_q[0];

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign rx_bit = loopback_i ? serial_out_o : serial_in_i;
`else
  assign rx_bit = serial_in_i;
`endif

  always_comb begin
    if (msb_q == SPI_MSB_FIRST) begin
      shifted = ((sreg_q << 1) | {{(DATA_LEN-1){1'b0}}, rx_bit}) & len_mask;
    end else begin
      shifted = (sreg_q >> 1) | ({{(DATA_LEN-1){1'b0}}, rx_bit} << top_idx);
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    rx_d    = rx_q;
    done_d  = 1'b0;
    len_d   = len_q;
    msb_d   = msb_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      SPI_IDLE: begin
        if (load_i) begin
          state_d = SPI_SHIFT;
          sreg_d  = tx_data_i & ~({DATA_LEN{1'b1}} << eff_len);
          len_d   = eff_len;
          msb_d   = msb_first_i;
          cnt_clr = 1'b1;
        end
      end
      SPI_SHIFT: begin
        // Abort wins over a coincident strobe.
        if (abort_i) begin
          state_d = SPI_IDLE;
          cnt_clr = 1'b1;
        end else if (shift_en_i) begin
          sreg_d = shifted;
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_d = SPI_IDLE;
            rx_d    = shifted;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = SPI_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SPI_IDLE;
      sreg_q  <= '0;
      rx_q    <= '0;
      done_q  <= 1'b0;
      len_q   <= CNT_W'(DATA_LEN);
      msb_q   <= SPI_LSB_FIRST;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
      len_q   <= len_d;
      msb_q   <= msb_d;
    end
  end

  spi_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .len_i  (len_q),
    .cnt_o  (bit_cnt_o),
    .last_o (cnt_last)
  );

  assign rx_data_o = rx_q;
  assign busy_o    = (state_q == SPI_SHIFT);
  assign done_o    = done_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine (DATA_LEN=8): directed scenarios plus randomized frames.
module tb_spi_shift_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, msb_first, shift_en, abort, serial_in;
  logic [7:0] tx_data;
  logic [3:0] frame_len;
  logic       serial_out, busy, done;
  logic [7:0] rx_data;
  logic [3:0] bit_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_shift_engine dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_i       (load),
    .tx_data_i    (tx_data),
    .frame_len_i  (frame_len),
    .msb_first_i  (msb_first),
    .shift_en_i   (shift_en),
    .abort_i      (abort),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loopback_i   (1'b0),
`endif
    .serial_in_i  (serial_in),
    .serial_out_o (serial_out),
    .rx_data_o    (rx_data),
    .busy_o       (busy),
    .done_o       (done),
    .bit_cnt_o    (bit_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input logic [3:0] flen);
    return (flen == 4'd0 || flen > 4'd8) ? 8 : int'(flen);
  endfunction

  // Frame model: line bit i is word bit i (LSB first) or bit L-1-i (MSB first),
  // both for transmit and receive; the received word is rxw masked to L bits.
  task automatic do_frame(input logic [7:0] tx, input logic [3:0] flen, input logic msb,
                          input logic [7:0] rxw, input int gap, input bit load_mid);
    int         L;
    int         pos;
    logic [7:0] exp_rx;
    L      = eff_len(flen);
    exp_rx = rxw & 8'((1 << L) - 1);
    load = 1'b1; tx_data = tx; frame_len = flen; msb_first = msb;
    step();
    load = 1'b0; tx_data = 8'($urandom); frame_len = 4'($urandom); msb_first = 1'($urandom);
    chk("start_busy", busy, 1);
    chk("start_cnt", bit_cnt, 0);
    chk("start_done", done, 0);
    for (int i = 0; i < L; i++) begin
      pos = msb ? (L - 1 - i) : i;
      for (int g = 0; g < gap; g++) begin
        step();
        chk("gap_cnt", bit_cnt, i);
        chk("gap_busy", busy, 1);
      end
      serial_in = rxw[pos];
      shift_en  = 1'b1;
      chk("serial_out", serial_out, tx[pos]);
      if (load_mid && i == 1) begin
        load = 1'b1; tx_data = 8'h00;
      end
      step();
      shift_en = 1'b0; load = 1'b0; serial_in = 1'($urandom);
      if (i < L - 1) begin
        chk("mid_busy", busy, 1);
        chk("mid_done", done, 0);
        chk("mid_cnt", bit_cnt, i + 1);
      end
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_rx", rx_data, exp_rx);
    chk("end_cnt", bit_cnt, L);
  endtask

  // One idle cycle with noise on strobes that IDLE must ignore.
  task automatic idle_cycle(input int L, input logic [7:0] exp_rx);
    shift_en = 1'($urandom); abort = 1'($urandom);
    step();
    shift_en = 1'b0; abort = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_cnt", bit_cnt, L);
    chk("idle_rx", rx_data, exp_rx);
  endtask

  initial begin
    logic [7:0] tx, rxw;
    logic [3:0] flen;
    logic       msb;
    rst_n = 1'b0; load = 1'b0; tx_data = '0; frame_len = '0; msb_first = 1'b0;
    shift_en = 1'b0; abort = 1'b0; serial_in = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", bit_cnt, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_sout", serial_out, 0);
    #20 rst_n = 1'b1;
    step();

    // Full 8-bit LSB-first frame, consecutive strobes.
    do_frame(8'hA5, 4'd8, 1'b0, 8'h3C, 0, 1'b0);
    idle_cycle(8, 8'h3C);

    // Strobe every third cycle, with a load attempt mid-frame.
    do_frame(8'hA5, 4'd8, 1'b0, 8'h3C, 2, 1'b1);
    idle_cycle(8, 8'h3C);

    // Abort after 3 strobes, coincident with a strobe.
    load = 1'b1; tx_data = 8'hA5; frame_len = 4'd8; msb_first = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift_en = 1'b1; serial_in = 1'($urandom);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0; shift_en = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rx", rx_data, 8'h3C);
    chk("abort_cnt", bit_cnt, 0);
    step();
    chk("abort_done2", done, 0);
    chk("abort_rx2", rx_data, 8'h3C);

    // MSB-first short frame, then frame_len 0 meaning full width.
    do_frame(8'h13, 4'd5, 1'b1, 8'h16, 0, 1'b0);
    idle_cycle(5, 8'h16);
    do_frame(8'hFF, 4'd0, 1'b1, 8'hFF, 0, 1'b0);
    idle_cycle(8, 8'hFF);

    // Back-to-back: second load issued in the done cycle of the first.
    do_frame(8'h11, 4'd8, 1'b0, 8'h11, 0, 1'b0);
    do_frame(8'h22, 4'd8, 1'b1, 8'h22, 0, 1'b0);
    idle_cycle(8, 8'h22);

    // Single-bit frame.
    do_frame(8'hFF, 4'd1, 1'b0, 8'h01, 0, 1'b0);
    idle_cycle(1, 8'h01);

    // Asynchronous reset between edges after 4 bits.
    load = 1'b1; tx_data = 8'hC3; frame_len = 4'd8; msb_first = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      shift_en = 1'b1; serial_in = 1'b1;
      step();
    end
    shift_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt", bit_cnt, 0);
    chk("arst_rx", rx_data, 0);
    chk("arst_sout", serial_out, 0);
    step();
    rst_n = 1'b1;
    step();
    do_frame(8'h5A, 4'd8, 1'b0, 8'h5A, 0, 1'b0);
    idle_cycle(8, 8'h5A);

    // Randomized frames, including saturating lengths and gaps.
    for (int k = 0; k < 40; k++) begin
      tx   = 8'($urandom);
      rxw  = 8'($urandom);
      flen = 4'($urandom_range(0, 15));
      msb  = 1'($urandom);
      do_frame(tx, flen, msb, rxw, $urandom_range(0, 2), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        idle_cycle(eff_len(flen), rxw & 8'((1 << eff_len(flen)) - 1));
      end
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
Parametrised SPI serialiser/deserialiser. It succeeds the fixed 8-bit LSB-first shift register with a configurable frame length, selectable bit order, a load/abort handshake, a bit counter, a done strobe and a held receive register. It sits between the SPI bit-timing logic (which supplies `shift_en` strobes) and the byte/word interface of the SPI master/slave core.

Parameters:
- DATA_LEN, 8, maximum frame width in bits; minimum 2.
- CNT_W, $clog2(DATA_LEN+1), width of `frame_len` and `bit_cnt`; derived, never overridden.

Ports:
- clk  in  1  — clock; all state updates on the rising edge.
- rst  in  1  — asynchronous reset, active-low.
- load  in  1  — start a frame; accepted only in IDLE.
- tx_data  in  DATA_LEN  — word to transmit; captured on an accepted `load`.
- frame_len  in  CNT_W  — bits per frame, 1..DATA_LEN; 0 means DATA_LEN; values above DATA_LEN saturate to DATA_LEN; captured on `load`.
- msb_first  in  1  — bit order; 1 = MSB first, 0 = LSB first; captured on `load`.
- shift_en  in  1  — bit strobe; one shift per cycle while asserted in SHIFT.
- abort  in  1  — cancel the current frame.
- serial_in  in  1  — receive bit.
- serial_out  out  1  — bit currently driven to the line.
- rx_data  out  DATA_LEN  — last completed received frame, right-justified, upper bits 0.
- busy  out  1  — high while in SHIFT.
- done  out  1  — one-cycle pulse on frame completion.
- bit_cnt  out  CNT_W  — bits shifted in the current frame.

Behaviour:
- Reset (`rst` low, asynchronous): `sreg`=0, `rx_data`=0, `busy`=0, `done`=0, `bit_cnt`=0, state=IDLE; `serial_out`=0. Reset takes effect immediately, including mid-frame.
- States: IDLE, SHIFT. `busy` = (state==SHIFT), registered.
- IDLE:
  - `shift_en` and `abort` are ignored.
  - `load`=1 → next cycle: state SHIFT, `bit_cnt`=0, `sreg` = `tx_data` with bits at and above the effective length L cleared; L and `msb_first` are latched.
- SHIFT, on an edge with `shift_en`=1:
  - LSB-first: `sreg` shifts right; `serial_in` enters bit L-1; `serial_out` = `sreg[0]`.
  - MSB-first: `sreg` shifts left within L bits; `serial_in` enters bit 0; `serial_out` = `sreg[L-1]`; bits ≥ L stay 0.
  - `bit_cnt` increments.
- Frame completion: on the edge where `bit_cnt` reaches L:
  - `rx_data` ← new `sreg` value;
  - `done`=1 for exactly one cycle;
  - state returns to IDLE (`busy`=0 in that same cycle);
  - `bit_cnt` holds at L until the next load.
- `serial_out` is combinational from `sreg`/latched config; in IDLE it shows the next bit to transmit.
- SHIFT with `shift_en`=0: everything holds; gaps of any length are legal.
- Abort: `abort`=1 in SHIFT → next cycle IDLE, `bit_cnt`=0, `rx_data` unchanged, no `done`. Abort has priority over `shift_en` on the same edge.
- `load` while `busy`: ignored; the frame continues unaffected.
- `load` in the `done` cycle: accepted; back-to-back frames have exactly one IDLE cycle between them.
- L=1: a single strobe completes the frame.

Optional Feature:
- Macro: SPI_SHIFT_LOOPBACK_EN.
- When defined: extra input port `loopback` (1 bit). When `loopback`=1, the internal receive bit = `serial_out` and `serial_in` is ignored, so after a frame `rx_data` equals `tx_data` masked to L bits.
- When undefined: the port does not exist and `serial_in` is always used.

Decomposition:
- Package `spi_pkg`:
  - state encoding constants `SPI_IDLE` / `SPI_SHIFT`;
  - order constants `SPI_LSB_FIRST` / `SPI_MSB_FIRST`;
  - `DATA_LEN` default;
  - clog2-based `CNT_W` helper.
- One sub-module `spi_bit_counter`: clear, enable, compare-to-L, terminal flag. The shift datapath and FSM stay in the top module.

Test Plan:
1. DATA_LEN=8, L=8, LSB-first: load 0xA5, then 8 consecutive strobes shifting in 0x3C LSB-first → `serial_out` sequence 1,0,1,0,0,1,0,1; `done` high one cycle after the 8th edge; `rx_data`=0x3C; `busy` 1→0.
2. MSB-first, `frame_len`=5: load 0x13, shift in bits 1,0,1,1,0 → `serial_out` sequence 1,0,0,1,1; `rx_data`=0x16; `frame_len`=0 with 0xFF in/out → `rx_data`=0xFF after 8 bits.
3. `shift_en` pulsed every third cycle over an 8-bit frame → same results as case 1; `bit_cnt` changes only on strobe edges; `load`=1 mid-frame with 0x00 has no effect.
4. Abort after 3 strobes (prior `rx_data`=0x3C) → `busy`=0 next cycle, no `done`, `rx_data` stays 0x3C, `bit_cnt`=0.
5. `load` in the `done` cycle → next frame starts with one IDLE gap; two frames 0x11/0x22 both received correctly.
6. `rst` driven low between edges after 4 bits → all outputs 0 immediately; after release, a fresh load of 0x5A completes normally.
